// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - float field constants shared by the radix-5 FFT stages
package fft_pkg;

  localparam int FP_W     = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;
  localparam int MAN_W    = EXP_LSB;

  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;

  localparam int N_PTS = 5;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PTS - 1);

  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
    return x[EXP_MSB:EXP_LSB];
  endfunction

endpackage

// File: rtl/fp_pow2_scale.sv
// rtl/fp_pow2_scale.sv - multiply one single-precision value by 2^-SHIFT
module fp_pow2_scale
  import fft_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic [FP_W-1:0] val_i,
  output logic [FP_W-1:0] val_o,
  output logic            flush_o
);

  localparam logic [EXP_W-1:0] SHIFT_E = EXP_W'(SHIFT);

  logic [EXP_W-1:0] exp_in;
  logic             sign_in;

  assign exp_in  = fp_exp(val_i);
  assign sign_in = val_i[SIGN_BIT];

  // Denormals are not produced: anything that would land at e<=0 becomes signed zero.
  always_comb begin
    val_o   = val_i;
    flush_o = 1'b0;
    if (exp_in == '0) begin
      val_o = {sign_in, {(FP_W-1){1'b0}}};
    end else if (exp_in == EXP_ALL1) begin
      val_o = val_i;
    end else if (exp_in <= SHIFT_E) begin
      val_o   = {sign_in, {(FP_W-1){1'b0}}};
      flush_o = 1'b1;
    end else begin
      val_o = {sign_in, exp_in - SHIFT_E, val_i[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/radix5_out_serializer.sv
// rtl/radix5_out_serializer.sv - ping-pong buffer turning 5 parallel complex results into a serial stream
module radix5_out_serializer
  import fft_pkg::*;
#(
  parameter int SCALE_SHIFT = 0,
  parameter int FP_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5*FP_W-1:0]     in_re,
  input  logic [5*FP_W-1:0]     in_img,
  input  logic                  in_conj,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FP_W-1:0]       out_re,
  output logic [FP_W-1:0]       out_img,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  uf_sticky
);

  logic [FP_W-1:0]  buf_re_q [2][N_PTS];
  logic [FP_W-1:0]  buf_re_d [2][N_PTS];
  logic [FP_W-1:0]  buf_im_q [2][N_PTS];
  logic [FP_W-1:0]  buf_im_d [2][N_PTS];
  logic [1:0]       full_q, full_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FP_W-1:0]  out_re_q, out_re_d;
  logic [FP_W-1:0]  out_img_q, out_img_d;
  logic             uf_q, uf_d;

  logic [FP_W-1:0]  sc_re [N_PTS];
  logic [FP_W-1:0]  sc_im [N_PTS];
  logic [N_PTS-1:0] fl_re, fl_im;
  logic             accept, out_hs, eop_hs;

  for (genvar k = 0; k < N_PTS; k++) begin : g_scale
    fp_pow2_scale #(.SHIFT(SCALE_SHIFT)) u_re (
      .val_i   (in_re[k*FP_W +: FP_W]),
      .val_o   (sc_re[k]),
      .flush_o (fl_re[k])
    );
    fp_pow2_scale #(.SHIFT(SCALE_SHIFT)) u_im (
      .val_i   (in_img[k*FP_W +: FP_W]),
      .val_o   (sc_im[k]),
      .flush_o (fl_im[k])
    );
  end

  assign in_ready  = ~(full_q[0] & full_q[1]);
  assign out_valid = full_q[rd_ptr_q];
  assign accept    = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign eop_hs    = out_hs & (idx_q == IDX_LAST);

  always_comb begin
    buf_re_d  = buf_re_q;
    buf_im_d  = buf_im_q;
    full_d    = full_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    idx_d     = idx_q;
    uf_d      = uf_q;
    out_re_d  = out_re_q;
    out_img_d = out_img_q;

    // The write bank is never the bank being read while it is full, so accept
    // and eop can both land in the same cycle without conflicting.
    if (accept) begin
      for (int k = 0; k < N_PTS; k++) begin
        buf_re_d[wr_ptr_q][k] = sc_re[k];
        buf_im_d[wr_ptr_q][k] = {sc_im[k][SIGN_BIT] ^ in_conj, sc_im[k][SIGN_BIT-1:0]};
      end
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
      uf_d             = uf_q | (|fl_re) | (|fl_im);
    end

    if (out_hs) begin
      if (eop_hs) begin
        idx_d            = '0;
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    // Output registers look ahead at next-state so sample 0 is visible right after accept.
    if (full_d[rd_ptr_d]) begin
      out_re_d  = buf_re_d[rd_ptr_d][idx_d];
      out_img_d = buf_im_d[rd_ptr_d][idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      idx_q     <= '0;
      uf_q      <= 1'b0;
      out_re_q  <= '0;
      out_img_q <= '0;
    end else begin
      full_q    <= full_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      idx_q     <= idx_d;
      uf_q      <= uf_d;
      out_re_q  <= out_re_d;
      out_img_q <= out_img_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_re_q <= buf_re_d;
    buf_im_q <= buf_im_d;
  end

  assign out_re    = out_re_q;
  assign out_img   = out_img_q;
  assign out_idx   = idx_q;
  assign out_sop   = (idx_q == '0);
  assign out_eop   = (idx_q == IDX_LAST);
  assign uf_sticky = uf_q;

endmodule

// File: tb/tb_radix5_out_serializer.sv
// tb/tb_radix5_out_serializer.sv - randomized bench against a sample-queue model of the serializer
module tb_radix5_out_serializer;

  localparam int SS = 2;
  localparam int NP = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, in_conj;
  logic [159:0] in_re, in_img;
  logic         out_valid, out_ready, out_sop, out_eop, uf_sticky;
  logic [31:0]  out_re, out_img;
  logic [2:0]   out_idx;

  always #5 clk = ~clk;

  radix5_out_serializer #(.SCALE_SHIFT(SS), .FP_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_img    (in_img),
    .in_conj   (in_conj),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_img   (out_img),
    .out_idx   (out_idx),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .uf_sticky (uf_sticky)
  );

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [2:0]  idx;
  } samp_t;

  samp_t       exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          exp_uf = 1'b0;
  logic [31:0] fr_re[NP];
  logic [31:0] fr_im[NP];
  bit          fr_conj;
  int          cur_run = 0;
  int          max_run = 0;
  int          last_idx = -1;
  int          sent;
  bit          a;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Value * 2^-SS on the float encoding, written as whole-word arithmetic.
  function automatic logic [31:0] xf(input logic [31:0] x, input bit neg, output bit fl);
    int          e;
    logic [31:0] r;
    e  = int'((x >> 23) & 32'hFF);
    fl = 1'b0;
    if (e == 0)        r = x & 32'h8000_0000;
    else if (e == 255) r = x;
    else if (e <= SS) begin
      r  = x & 32'h8000_0000;
      fl = 1'b1;
    end else           r = x - 32'(SS << 23);
    if (neg) r = r ^ 32'h8000_0000;
    return r;
  endfunction

  function automatic logic [31:0] rand_comp();
    logic [7:0] e;
    case ($urandom_range(0, 7))
      0:       e = 8'd0;
      1:       e = 8'd1;
      2:       e = 8'(SS);
      3:       e = 8'(SS + 1);
      4:       e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic rand_frame();
    for (int k = 0; k < NP; k++) begin
      fr_re[k] = rand_comp();
      fr_im[k] = rand_comp();
    end
    fr_conj = 1'($urandom);
  endtask

  task automatic cycle(input bit offer, input bit ordy, output bit acc);
    samp_t d;
    @(negedge clk);
    in_valid  = offer;
    out_ready = ordy;
    in_conj   = fr_conj;
    for (int k = 0; k < NP; k++) begin
      in_re[k*32 +: 32]  = fr_re[k];
      in_img[k*32 +: 32] = fr_im[k];
    end
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("in_ready", in_ready, ((exp_q.size() + 4) / 5) < 2);
    chk("uf_sticky", uf_sticky, exp_uf);
    if (out_valid) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else cur_run = 0;
    acc = 1'b0;
    if (out_valid && exp_q.size() != 0) begin
      chk("out_re", out_re, exp_q[0].re);
      chk("out_img", out_img, exp_q[0].im);
      chk("out_idx", out_idx, exp_q[0].idx);
      chk("out_sop", out_sop, exp_q[0].idx == 3'd0);
      chk("out_eop", out_eop, exp_q[0].idx == 3'd4);
      if (out_ready) begin
        d        = exp_q.pop_front();
        last_idx = int'(d.idx);
      end
    end
    if (in_valid && in_ready) begin
      acc = 1'b1;
      for (int k = 0; k < NP; k++) begin
        samp_t s;
        bit    f1, f2;
        s.re  = xf(fr_re[k], 1'b0, f1);
        s.im  = xf(fr_im[k], fr_conj, f2);
        s.idx = 3'(k);
        if (f1 || f2) exp_uf = 1'b1;
        exp_q.push_back(s);
      end
    end
    @(posedge clk);
  endtask

  task automatic drain();
    bit x;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle(1'b0, 1'b1, x);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; in_conj = 1'b0;
    in_re = '0; in_img = '0; fr_conj = 1'b0;
    for (int k = 0; k < NP; k++) begin fr_re[k] = '0; fr_im[k] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_uf", uf_sticky, 0);
    chk("rst_re", out_re, 0);
    chk("rst_img", out_img, 0);
    chk("rst_idx", out_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain frame: 1.0 / 2.0 scaled by 1/4
    for (int k = 0; k < NP; k++) begin fr_re[k] = 32'h3F80_0000; fr_im[k] = 32'h4000_0000; end
    fr_conj = 1'b0;
    cycle(1'b1, 1'b1, a);
    chk("basic_acc", a, 1);
    #1;
    chk("basic_valid", out_valid, 1);
    chk("basic_re", out_re, 32'h3E80_0000);
    chk("basic_img", out_img, 32'h3F00_0000);
    chk("basic_sop", out_sop, 1);
    drain();

    fr_conj = 1'b1;
    cycle(1'b1, 1'b1, a);
    #1;
    chk("conj_re", out_re, 32'h3E80_0000);
    chk("conj_img", out_img, 32'hBF00_0000);
    drain();

    fr_re[0] = 32'h0080_0000; fr_re[1] = 32'h7F80_0000; fr_re[2] = 32'h8000_0000;
    fr_re[3] = 32'h0100_0000; fr_re[4] = 32'h0180_0000;
    fr_im[0] = 32'h8080_0000; fr_im[1] = 32'hFF80_0000; fr_im[2] = 32'h0000_0000;
    fr_im[3] = 32'h3F80_0000; fr_im[4] = 32'h7FC0_0001;
    fr_conj = 1'b1;
    cycle(1'b1, 1'b1, a);
    #1;
    chk("bnd_re0", out_re, 32'h0000_0000);
    chk("bnd_img0", out_img, 32'h0000_0000);
    chk("bnd_uf", uf_sticky, 1);
    drain();

    // Three frames offered back to back, sink always ready
    rand_frame();
    sent = 0; max_run = 0; cur_run = 0;
    for (int i = 0; i < 25; i++) begin
      cycle(sent < 3, 1'b1, a);
      if (a) begin sent++; rand_frame(); end
    end
    chk("b2b_frames", sent, 3);
    chk("b2b_run", max_run, 15);
    drain();

    // Sink stalled for 12 cycles: both banks fill and sample 0 holds
    sent = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, a);
      if (a) begin sent++; rand_frame(); end
    end
    chk("bp_frames", sent, 2);
    #1;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_idx", out_idx, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(sent < 3, 1'b1, a);
      if (a) begin sent++; rand_frame(); end
    end
    drain();

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a);
      if (a) rand_frame();
    end
    drain();

    // Reset while idx 3 is on the output
    rand_frame();
    cycle(1'b1, 1'b1, a);
    last_idx = -1;
    for (int i = 0; i < 10 && last_idx != 2; i++) cycle(1'b0, 1'b1, a);
    chk("mid_reach", last_idx, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_uf", uf_sticky, 0);
    chk("mid_idx", out_idx, 0);
    exp_q.delete();
    exp_uf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, a);
    rand_frame();
    cycle(1'b1, 1'b1, a);
    #1;
    chk("mid_new_idx", out_idx, 0);
    chk("mid_new_valid", out_valid, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
